ex_mul_seq: RTL and testbench
=============================

// Module: ex_mul_seq
// PURPOSE
//  Multi-cycle MUL sequencer (RV32M MUL, low 32 bits of product) sitting beside the EX-stage ALU.
//  Computes the product by shift-and-add and drives the shared ALU for the adds.
//  Owns operand/accumulator registers and the ALU request; the EX mux grants it the ALU while the pipeline stalls.
//  Signed and unsigned MUL share one path (low word is sign-agnostic).
// PARAMETERS
//  XLEN    32  operand/result width
//  CNT_W   5   iteration counter width, log2(XLEN)
// PORTS
//  clk           in   1     clock
//  rst           in   1     asynchronous reset, active-high
//  start_valid   in   1     new MUL request
//  start_ready   out  1     sequencer idle, request accepted this cycle if start_valid=1
//  start_a       in   XLEN  multiplicand (rs1)
//  start_b       in   XLEN  multiplier (rs2)
//  flush         in   1     pipeline flush; abort current operation
//  alu_req       out  1     sequencer wants the ALU this cycle
//  alu_gnt       in   1     ALU granted this cycle (combinational from EX mux)
//  alu_op        out  4     ALU opcode, `ALU_ADD when alu_req=1, else 4'b0
//  alu_a         out  XLEN  ALU operand A = accumulator
//  alu_b         out  XLEN  ALU operand B = shifted multiplicand
//  alu_c         in   XLEN  ALU result
//  res_valid     out  1     product available
//  res_ready     in   1     consumer takes product
//  res_data      out  XLEN  product low word
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, mcand=0, mplier=0, cnt=0; start_ready=1, alu_req=0, alu_op=0, alu_a=0,
//   alu_b=0, res_valid=0, res_data=0.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: start_ready=1. On start_valid: acc<=0, mcand<=start_a, mplier<=start_b, cnt<=0, ->RUN.
//  RUN: start_ready=0. alu_req=mplier[0]; alu_a=acc, alu_b=mcand, alu_op=`ALU_ADD when alu_req=1.
//   Iteration advances only if (mplier[0]=0) or (alu_gnt=1):
//    acc<=alu_c if mplier[0] else unchanged; mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
//   If mplier[0]=1 and alu_gnt=0: hold all registers, keep alu_req=1 (stall, no limit).
//   Exit to DONE on the advancing cycle where cnt==XLEN-1 (or early rule below).
//  DONE: res_valid=1, res_data=acc, held stable until res_ready=1; then ->IDLE, res_valid=0 next cycle.
//  Latency (alu_gnt always 1): accept at edge k, RUN for XLEN cycles, res_valid high in cycle k+XLEN+1.
//  Arithmetic: all adds mod 2^XLEN; mcand bits shifted past MSB are discarded.
//  flush (any state): ->IDLE next edge, res_valid=0, alu_req=0; a start_valid in the same cycle is ignored.
//  A start_valid outside IDLE is not accepted (start_ready=0); no queueing.
//  rst mid-operation: immediate return to reset values; the partial product is lost.
//  alu_gnt is ignored whenever alu_req=0.
// CONFIGURATION
//  MULSEQ_EARLY_EN defined: RUN also exits to DONE on any advancing cycle where (mplier>>1)==0.
//   RUN length = max(1, index of highest set bit of start_b + 1).
//  Undefined: RUN is always exactly XLEN advancing cycles.
//  Result value is identical either way.
// STRUCTURE
//  defines.vh (shared): `ALU_ADD and the other ALU opcodes, plus `ALU_OP_W=4.
//   Add MUL-sequencer state encodings there (`MSEQ_IDLE/RUN/DONE) so the hazard unit can decode busy.
//  Single flat module; no sub-module.
//  The ALU itself and the grant mux are instantiated at EX-stage top level, not inside this block.
// TESTING
//  a=3, b=5, gnt=1: res_data=15.
//   res_valid at k+33 without MULSEQ_EARLY_EN; at k+4 with it (3 RUN cycles).
//  a=0xFFFFFFFF, b=0xFFFFFFFF: res_data=0x00000001.
//   alu_req=1 in every RUN cycle; 32 RUN cycles in both configs.
//  a=7, b=0x80000001, gnt held low for 4 cycles in first RUN cycle:
//   registers frozen, alu_req=1 throughout; res_data=0x80000007, latency +4.
//  a=2, b=0: no alu_req ever; res_data=0; RUN length 1 with EARLY_EN, 32 without.
//  flush asserted at RUN cycle 10 with start_valid=1:
//   IDLE next edge, request ignored; a later a=6, b=7 gives 42.
//  res_ready=0 for 5 cycles in DONE: res_valid/res_data stable, start_ready=0;
//   IDLE one cycle after res_ready=1; rst asserted mid-RUN returns all outputs to reset values.

Source files
------------

// File: rtl/ex_mul_seq_pkg.sv
// Shared constants for the EX-stage MUL sequencer: ALU opcodes and sequencer state
// encoding (exported so the hazard unit can decode busy).
package ex_mul_seq_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned CNT_W_DEF = 5;
    localparam int unsigned ALU_OP_W  = 4;

    localparam logic [ALU_OP_W-1:0] ALU_NOP = 4'h0;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'h1;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'h2;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'h3;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'h4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'h5;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'h6;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'h7;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'h8;

    typedef enum logic [1:0] {
        MSEQ_IDLE = 2'd0,
        MSEQ_RUN  = 2'd1,
        MSEQ_DONE = 2'd2
    } mseq_state_e;

    function automatic logic mseq_busy(input mseq_state_e s);
        return s != MSEQ_IDLE;
    endfunction

endpackage

// File: rtl/ex_mul_seq_if.sv
// Handshake/ALU bundle between the EX stage (master) and the MUL sequencer (slave).
interface ex_mul_seq_if #(
    parameter int unsigned XLEN = 32
);
    import ex_mul_seq_pkg::*;

    logic                start_valid;
    logic                start_ready;
    logic [XLEN-1:0]     start_a;
    logic [XLEN-1:0]     start_b;

    logic                alu_req;
    logic                alu_gnt;
    logic [ALU_OP_W-1:0] alu_op;
    logic [XLEN-1:0]     alu_a;
    logic [XLEN-1:0]     alu_b;
    logic [XLEN-1:0]     alu_c;

    logic                res_valid;
    logic                res_ready;
    logic [XLEN-1:0]     res_data;

    modport master (
        output start_valid, start_a, start_b, alu_gnt, alu_c, res_ready,
        input  start_ready, alu_req, alu_op, alu_a, alu_b, res_valid, res_data
    );

    modport slave (
        input  start_valid, start_a, start_b, alu_gnt, alu_c, res_ready,
        output start_ready, alu_req, alu_op, alu_a, alu_b, res_valid, res_data
    );

endinterface

// File: rtl/ex_mul_seq.sv
// Shift-and-add MUL sequencer (low XLEN bits) borrowing the shared EX ALU for the adds.
// Define MULSEQ_EARLY_EN to leave RUN as soon as no multiplier bits remain.
module ex_mul_seq
    import ex_mul_seq_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    ex_mul_seq_if.slave   bus
);

    mseq_state_e      r_state;
    logic [XLEN-1:0]  r_acc;
    logic [XLEN-1:0]  r_mcand;
    logic [XLEN-1:0]  r_mplier;
    logic [CNT_W-1:0] r_cnt;

    logic w_need_add;
    logic w_advance;
    logic w_last;

    assign w_need_add = r_mplier[0];
    // gnt only matters when an add is actually needed this iteration
    assign w_advance  = !w_need_add || bus.alu_gnt;

`ifdef MULSEQ_EARLY_EN
    assign w_last = (r_cnt == CNT_W'(XLEN - 1)) || ((r_mplier >> 1) == '0);
`else
    assign w_last = (r_cnt == CNT_W'(XLEN - 1));
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= MSEQ_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_state <= MSEQ_IDLE;
        end else begin
            case (r_state)
                MSEQ_IDLE: begin
                    if (bus.start_valid) begin
                        r_acc    <= '0;
                        r_mcand  <= bus.start_a;
                        r_mplier <= bus.start_b;
                        r_cnt    <= '0;
                        r_state  <= MSEQ_RUN;
                    end
                end
                MSEQ_RUN: begin
                    if (w_advance) begin
                        if (w_need_add) begin
                            r_acc <= bus.alu_c;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= MSEQ_DONE;
                        end
                    end
                end
                MSEQ_DONE: begin
                    if (bus.res_ready) begin
                        r_state <= MSEQ_IDLE;
                    end
                end
                default: r_state <= MSEQ_IDLE;
            endcase
        end
    end

    assign bus.start_ready = (r_state == MSEQ_IDLE);
    assign bus.alu_req     = (r_state == MSEQ_RUN) && w_need_add;
    assign bus.alu_op      = bus.alu_req ? ALU_ADD : '0;
    assign bus.alu_a       = r_acc;
    assign bus.alu_b       = r_mcand;
    assign bus.res_valid   = (r_state == MSEQ_DONE);
    assign bus.res_data    = bus.res_valid ? r_acc : '0;

endmodule

// File: tb/tb_ex_mul_seq.sv
// Directed + randomized bench for ex_mul_seq against an arithmetic product/latency model.
module tb_ex_mul_seq;
    import ex_mul_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    int total = 0;
    int bad   = 0;

    ex_mul_seq_if #(.XLEN(32)) bus ();

    ex_mul_seq #(.XLEN(32), .CNT_W(5)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .bus     (bus)
    );

    // EX-stage ALU stand-in: always adds
    assign bus.alu_c = bus.alu_a + bus.alu_b;

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int run_len(input logic [31:0] b);
`ifdef MULSEQ_EARLY_EN
        int n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        return n;
`else
        return 32;
`endif
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".start_ready"}, 32'(bus.start_ready), 32'd1);
        chk({tag, ".alu_req"},     32'(bus.alu_req),     32'd0);
        chk({tag, ".alu_op"},      32'(bus.alu_op),      32'd0);
        chk({tag, ".alu_a"},       bus.alu_a,            32'd0);
        chk({tag, ".alu_b"},       bus.alu_b,            32'd0);
        chk({tag, ".res_valid"},   32'(bus.res_valid),   32'd0);
        chk({tag, ".res_data"},    bus.res_data,         32'd0);
    endtask

    // One full MUL: model says after i advancing iterations the ALU sees
    // acc = a * (b mod 2^i), mcand = a << i, and an add is requested iff b[i].
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input int stall_first, input bit rnd_stall,
                           input int hold, input string tag);
        logic [31:0] exp_p;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [63:0] mask;
        logic        exp_req;
        int iter, stalls, cycles, exp_len;
        bit done;
        exp_p   = a * b;
        exp_len = run_len(b);
        iter = 0; stalls = 0; cycles = 0; done = 1'b0;

        @(negedge clk);
        chk({tag, ".idle_rdy"}, 32'(bus.start_ready), 32'd1);
        bus.start_valid = 1'b1;
        bus.start_a     = a;
        bus.start_b     = b;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        bus.start_a     = $urandom;
        bus.start_b     = $urandom;

        while (!done) begin
            @(negedge clk);
            if (bus.res_valid) begin
                done = 1'b1;
            end else if (cycles > 300) begin
                chk({tag, ".timeout"}, 32'(cycles), 32'(exp_len + stalls));
                done = 1'b1;
            end else begin
                mask    = (64'd1 << iter) - 64'd1;
                exp_a   = a * (b & mask[31:0]);
                exp_b   = a << iter;
                exp_req = (iter < 32) ? b[iter[4:0]] : 1'b0;
                chk({tag, ".run_rdy"}, 32'(bus.start_ready), 32'd0);
                chk({tag, ".alu_req"}, 32'(bus.alu_req), 32'(exp_req));
                chk({tag, ".alu_op"},  32'(bus.alu_op), exp_req ? 32'(ALU_ADD) : 32'd0);
                chk({tag, ".alu_a"},   bus.alu_a, exp_a);
                chk({tag, ".alu_b"},   bus.alu_b, exp_b);
                if (exp_req) begin
                    if (stalls < stall_first || (rnd_stall && $urandom_range(0, 3) == 0)) begin
                        bus.alu_gnt = 1'b0;
                        stalls++;
                    end else begin
                        bus.alu_gnt = 1'b1;
                        iter++;
                    end
                end else begin
                    bus.alu_gnt = 1'($urandom_range(0, 1));
                    iter++;
                end
                @(posedge clk);
                cycles++;
            end
        end
        bus.alu_gnt = 1'b0;

        chk({tag, ".latency"},  32'(cycles), 32'(exp_len + stalls));
        chk({tag, ".iters"},    32'(iter), 32'(exp_len));
        chk({tag, ".res_data"}, bus.res_data, exp_p);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(bus.res_valid), 32'd1);
            chk({tag, ".hold_data"},  bus.res_data, exp_p);
            chk({tag, ".hold_rdy"},   32'(bus.start_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".post_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, ".post_rdy"},   32'(bus.start_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bus.start_valid = 1'b0;
        bus.start_a     = '0;
        bus.start_b     = '0;
        bus.alu_gnt     = 1'b0;
        bus.res_ready   = 1'b0;

        // Reset state
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("after_reset");

        // Directed cases
        run_mul(32'd3, 32'd5, 0, 1'b0, 0, "mul3x5");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 0, "mulff");
        run_mul(32'd7, 32'h8000_0001, 4, 1'b0, 0, "stall4");
        run_mul(32'd2, 32'd0, 0, 1'b0, 0, "mulzero");

        // Flush during RUN with a simultaneous start that must be ignored
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.start_a     = 32'h1234_5678;
        bus.start_b     = 32'h8000_0003;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        bus.alu_gnt     = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush           = 1'b1;
        bus.start_valid = 1'b1;
        bus.start_a     = 32'd9;
        bus.start_b     = 32'd9;
        @(posedge clk);
        #1;
        flush           = 1'b0;
        bus.start_valid = 1'b0;
        bus.alu_gnt     = 1'b0;
        @(negedge clk);
        chk("flush.rdy",   32'(bus.start_ready), 32'd1);
        chk("flush.valid", 32'(bus.res_valid),   32'd0);
        chk("flush.req",   32'(bus.alu_req),     32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("flush.still_idle", 32'(bus.start_ready), 32'd1);
        run_mul(32'd6, 32'd7, 0, 1'b0, 0, "after_flush");

        // Consumer back-pressure in DONE
        run_mul($urandom, $urandom, 0, 1'b0, 5, "hold5");

        // Random operands, random stalls, varied multiplier widths
        for (int n = 0; n < 12; n++) begin
            ra = $urandom;
            rb = $urandom;
            rb = rb >> $urandom_range(0, 31);
            run_mul(ra, rb, 0, 1'b1, $urandom_range(0, 2), "rand");
        end

        // Asynchronous reset mid-RUN
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.start_a     = 32'hDEAD_BEEF;
        bus.start_b     = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        bus.alu_gnt     = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("midrun.busy", 32'(bus.start_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrun_rst");
        bus.alu_gnt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("post_rst");
        run_mul(32'd11, 32'd13, 0, 1'b0, 0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
